// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bundle bus: instruction handshake in, decoded ALU/memory/branch controls out.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      alu_op;
    logic            alu_sub_sra;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic            illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, alu_sub_sra, a_sel, b_sel, imm,
               rd, rs1, rs2, reg_write, mem_read, mem_write, branch, jump, funct3, illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, alu_op, alu_sub_sra, a_sel, b_sel, imm,
               rd, rs1, rs2, reg_write, mem_read, mem_write, branch, jump, funct3, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers the decoded bundle for execute with a 1-cycle valid/ready pipeline.
// Optional `DECODE_SKID_BUFFER_EN adds a one-entry skid so in_ready comes straight from a flop.
module decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset_n,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      alu_op;
        logic            alu_sub_sra;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } bundle_t;

    function automatic bundle_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        bundle_t                b;
        logic [6:0]             opc;
        logic [6:0]             f7;
        logic [2:0]             f3;
        logic                   wr;
        logic signed [XLEN-1:0] i_imm;
        logic signed [XLEN-1:0] s_imm;
        logic signed [XLEN-1:0] b_imm;
        logic signed [XLEN-1:0] u_imm;
        logic signed [XLEN-1:0] j_imm;
        logic        [XLEN-1:0] sh_imm;
        opc    = inst[6:0];
        f3     = inst[14:12];
        f7     = inst[31:25];
        i_imm  = XLEN'($signed(inst[31:20]));
        s_imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
        b_imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        u_imm  = XLEN'($signed({inst[31:12], 12'b0}));
        j_imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        sh_imm = {{(XLEN-5){1'b0}}, inst[24:20]};
        b        = '0;
        b.pc     = pc;
        b.rd     = inst[11:7];
        b.rs1    = inst[19:15];
        b.rs2    = inst[24:20];
        b.funct3 = f3;
        wr       = 1'b0;
        case (opc)
            OPC_OP: begin
                b.alu_op      = f3;
                b.alu_sub_sra = inst[30];
                wr            = 1'b1;
                if (f7 == 7'b0100000) b.illegal = !(f3 == 3'b000 || f3 == 3'b101);
                else                  b.illegal = (f7 != 7'b0000000);
            end
            OPC_OPIMM: begin
                b.alu_op = f3;
                b.b_sel  = 1'b1;
                wr       = 1'b1;
                if (f3 == 3'b001) begin
                    b.imm     = sh_imm;
                    b.illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    b.imm         = sh_imm;
                    b.alu_sub_sra = inst[30];
                    b.illegal     = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end else begin
                    b.imm = i_imm;
                end
            end
            OPC_LUI: begin
                b.a_sel = 2'd2;
                b.b_sel = 1'b1;
                b.imm   = u_imm;
                wr      = 1'b1;
            end
            OPC_AUIPC: begin
                b.a_sel = 2'd1;
                b.b_sel = 1'b1;
                b.imm   = u_imm;
                wr      = 1'b1;
            end
            OPC_LOAD: begin
                b.b_sel    = 1'b1;
                b.imm      = i_imm;
                b.mem_read = 1'b1;
                wr         = 1'b1;
            end
            OPC_STORE: begin
                b.b_sel     = 1'b1;
                b.imm       = s_imm;
                b.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                b.branch      = 1'b1;
                b.alu_sub_sra = 1'b1;
                b.imm         = b_imm;
            end
            OPC_JAL: begin
                b.jump  = 1'b1;
                b.a_sel = 2'd1;
                b.b_sel = 1'b1;
                b.imm   = j_imm;
                wr      = 1'b1;
            end
            OPC_JALR: begin
                b.jump  = 1'b1;
                b.b_sel = 1'b1;
                b.imm   = i_imm;
                wr      = 1'b1;
            end
            default: b.illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) b.illegal = 1'b1;
        // Illegal words must never have architectural side effects downstream.
        b.reg_write = wr && (b.rd != 5'd0) && !b.illegal;
        if (b.illegal) begin
            b.mem_read  = 1'b0;
            b.mem_write = 1'b0;
            b.branch    = 1'b0;
            b.jump      = 1'b0;
        end
        return b;
    endfunction

    bundle_t dec_p0;
    bundle_t bnd_p1;
    logic    vld_p1;
    logic    in_ready;

    assign dec_p0 = decode(bus.in_inst, bus.in_pc);

`ifdef DECODE_SKID_BUFFER_EN
    bundle_t skid_p1;
    logic    skid_vld_p1;
    logic    accept_p0;
    logic    main_free_p0;

    assign in_ready     = !skid_vld_p1;
    assign accept_p0    = bus.in_valid && in_ready;
    assign main_free_p0 = !vld_p1 || bus.out_ready;

    // ---- p0 -> p1: main register refills from the skid first to keep order ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            bnd_p1      <= '0;
            bnd_p1.pc   <= RESET_PC;
        end else if (bus.flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (main_free_p0) begin
            if (skid_vld_p1) begin
                vld_p1      <= 1'b1;
                bnd_p1      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= accept_p0;
                if (accept_p0) bnd_p1 <= dec_p0;
            end
        end else if (accept_p0) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!main_free_p0 && accept_p0) skid_p1 <= dec_p0;
    end
`else
    assign in_ready = !vld_p1 || bus.out_ready;

    // ---- p0 -> p1: single bundle register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            bnd_p1    <= '0;
            bnd_p1.pc <= RESET_PC;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) bnd_p1 <= dec_p0;
        end
    end
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_p1;
    assign bus.out_pc      = bnd_p1.pc;
    assign bus.alu_op      = bnd_p1.alu_op;
    assign bus.alu_sub_sra = bnd_p1.alu_sub_sra;
    assign bus.a_sel       = bnd_p1.a_sel;
    assign bus.b_sel       = bnd_p1.b_sel;
    assign bus.imm         = bnd_p1.imm;
    assign bus.rd          = bnd_p1.rd;
    assign bus.rs1         = bnd_p1.rs1;
    assign bus.rs2         = bnd_p1.rs2;
    assign bus.reg_write   = bnd_p1.reg_write;
    assign bus.mem_read    = bnd_p1.mem_read;
    assign bus.mem_write   = bnd_p1.mem_write;
    assign bus.branch      = bnd_p1.branch;
    assign bus.jump        = bnd_p1.jump;
    assign bus.funct3      = bnd_p1.funct3;
    assign bus.illegal     = bnd_p1.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode fields, handshake stall, flush and async reset.
module tb_decode_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef DECODE_SKID_BUFFER_EN
    localparam int SKID_EXTRA = 1;
`else
    localparam int SKID_EXTRA = 0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] words [3];
    int sent, got, acc_stall;

    initial begin
        words[0] = 32'h0010_0093;  // addi x1,x0,1
        words[1] = 32'h0020_0113;  // addi x2,x0,2
        words[2] = 32'h0030_0193;  // addi x3,x0,3
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        expect_eq("rst_valid", bus.out_valid, 0);
        expect_eq("rst_pc", bus.out_pc, RST_PC);
        expect_eq("rst_imm", bus.imm, 0);
        expect_eq("rst_rd", bus.rd, 0);
        expect_eq("rst_regwr", bus.reg_write, 0);
        expect_eq("rst_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        tick();

        // ADD x3,x1,x2
        send(32'h0020_81B3, 32'h0000_1000);
        expect_eq("add_valid", bus.out_valid, 1);
        expect_eq("add_op", bus.alu_op, 0);
        expect_eq("add_sub", bus.alu_sub_sra, 0);
        expect_eq("add_rs1", bus.rs1, 1);
        expect_eq("add_rs2", bus.rs2, 2);
        expect_eq("add_rd", bus.rd, 3);
        expect_eq("add_bsel", bus.b_sel, 0);
        expect_eq("add_regwr", bus.reg_write, 1);
        expect_eq("add_pc", bus.out_pc, 32'h1000);
        expect_eq("add_illegal", bus.illegal, 0);

        // SUB then SRAI x5,x6,3 back-to-back
        bus.in_valid = 1'b1; bus.in_inst = 32'h4020_81B3; bus.in_pc = 32'h1004;
        tick();
        expect_eq("sub_sub", bus.alu_sub_sra, 1);
        expect_eq("sub_op", bus.alu_op, 0);
        bus.in_inst = 32'h4033_5293; bus.in_pc = 32'h1008;
        tick();
        bus.in_valid = 1'b0;
        expect_eq("srai_op", bus.alu_op, 3'b101);
        expect_eq("srai_sra", bus.alu_sub_sra, 1);
        expect_eq("srai_imm", bus.imm, 32'h0000_0003);
        expect_eq("srai_bsel", bus.b_sel, 1);
        expect_eq("srai_rd", bus.rd, 5);
        expect_eq("srai_rs1", bus.rs1, 6);
        expect_eq("srai_pc", bus.out_pc, 32'h1008);
        tick();
        expect_eq("drain_valid", bus.out_valid, 0);

        // ADDI x1,x0,-1 and ADDI x0,x0,0
        send(32'hFFF0_0093, 32'h100C);
        expect_eq("addi_imm", bus.imm, 32'hFFFF_FFFF);
        expect_eq("addi_op", bus.alu_op, 0);
        expect_eq("addi_asel", bus.a_sel, 0);
        expect_eq("addi_bsel", bus.b_sel, 1);
        expect_eq("addi_regwr", bus.reg_write, 1);
        send(32'h0000_0013, 32'h1010);
        expect_eq("nop_regwr", bus.reg_write, 0);
        expect_eq("nop_illegal", bus.illegal, 0);

        // illegal encodings
        send(32'h0000_0000, 32'h1014);
        expect_eq("zero_illegal", bus.illegal, 1);
        expect_eq("zero_regwr", bus.reg_write, 0);
        expect_eq("zero_valid", bus.out_valid, 1);
        send(32'h0420_81B3, 32'h1018);
        expect_eq("f7_illegal", bus.illegal, 1);
        expect_eq("f7_regwr", bus.reg_write, 0);
        send(32'h0220_9093, 32'h101C);  // slli x1,x1,2 with inst[25] set
        expect_eq("slli_illegal", bus.illegal, 1);

        // LUI x7,0x12345
        send(32'h1234_53B7, 32'h1020);
        expect_eq("lui_imm", bus.imm, 32'h1234_5000);
        expect_eq("lui_asel", bus.a_sel, 2);
        expect_eq("lui_bsel", bus.b_sel, 1);
        // SW x2,-4(x1)
        send(32'hFE20_AE23, 32'h1024);
        expect_eq("sw_imm", bus.imm, 32'hFFFF_FFFC);
        expect_eq("sw_memwr", bus.mem_write, 1);
        expect_eq("sw_regwr", bus.reg_write, 0);
        expect_eq("sw_f3", bus.funct3, 3'b010);
        // BEQ x1,x2,-8
        send(32'hFE20_8CE3, 32'h1028);
        expect_eq("beq_imm", bus.imm, 32'hFFFF_FFF8);
        expect_eq("beq_branch", bus.branch, 1);
        expect_eq("beq_sub", bus.alu_sub_sra, 1);
        expect_eq("beq_bsel", bus.b_sel, 0);
        expect_eq("beq_regwr", bus.reg_write, 0);
        // JAL x1,+16
        send(32'h0100_00EF, 32'h102C);
        expect_eq("jal_imm", bus.imm, 32'h0000_0010);
        expect_eq("jal_jump", bus.jump, 1);
        expect_eq("jal_asel", bus.a_sel, 1);
        expect_eq("jal_regwr", bus.reg_write, 1);

        // stall: out_ready low for cycles 1..5 with words always on offer
        bus.out_ready = 1'b1;
        tick();
        sent = 0; got = 0; acc_stall = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (got >= 3) break;
            bus.out_ready = !(cyc >= 1 && cyc <= 5);
            bus.in_valid  = (sent < 3);
            bus.in_inst   = words[(sent < 3) ? sent : 0];
            bus.in_pc     = 32'h2000 + 32'(sent * 4);
            #1;
            if (cyc >= 1 && cyc <= 5) begin
                expect_eq("stall_valid", bus.out_valid, 1);
                expect_eq("stall_rd", bus.rd, 1);
                expect_eq("stall_pc", bus.out_pc, 32'h2000);
                if (bus.in_valid && bus.in_ready) acc_stall++;
            end
            if (bus.out_valid && bus.out_ready) begin
                expect_eq("stream_rd", bus.rd, 64'(got + 1));
                expect_eq("stream_pc", bus.out_pc, 64'(32'h2000 + got * 4));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid = 1'b0;
        expect_eq("stream_count", got, 3);
        expect_eq("stall_accepts", acc_stall, SKID_EXTRA);

        // flush during a stall, with a word offered in the same cycle
        send(32'h0040_0213, 32'h3000);
        bus.out_ready = 1'b0;
        tick();
        expect_eq("hold_rd", bus.rd, 4);
        expect_eq("hold_valid", bus.out_valid, 1);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_inst = 32'h0050_0293; bus.in_pc = 32'h3004;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        expect_eq("flush_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick();
        expect_eq("flush_dropped", bus.out_valid, 0);
        send(32'h0020_81B3, 32'h3100);
        expect_eq("postflush_valid", bus.out_valid, 1);
        expect_eq("postflush_rd", bus.rd, 3);
        expect_eq("postflush_pc", bus.out_pc, 32'h3100);

        // async reset mid-stall
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = words[0]; bus.in_pc = 32'h4000;
        tick();
        #2 reset_n = 1'b0;
        #1;
        expect_eq("arst_valid", bus.out_valid, 0);
        expect_eq("arst_pc", bus.out_pc, RST_PC);
        expect_eq("arst_rd", bus.rd, 0);
        bus.in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        send(32'hFFF0_0093, 32'h4100);
        expect_eq("postrst_valid", bus.out_valid, 1);
        expect_eq("postrst_imm", bus.imm, 32'hFFFF_FFFF);
        expect_eq("postrst_rd", bus.rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
